// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the IF-stage fetch controller
// Purpose: fetch FSM state encoding, default reset PC / NOP word, word-align helper.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IF_BOOT = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_if_id_reg.sv
// rtl/pc_fetch_if_id_reg.sv - IF/ID pipeline register with load, hold and flush
// Purpose: holds the instruction handed to decode.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   flush_i            kill contents (valid=0, inst=NOP); highest priority
//   load_i             capture pc_i/inst_i as a live instruction
//   stall_i            hold contents when nothing loads; otherwise insert a bubble
//   pc_i, inst_i       data to load
//   valid_o, pc_o, inst_o  register contents
module pc_fetch_if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end else if (!stall_i) begin
      // Decode consumed the old entry and nothing new arrived: bubble.
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register and instruction-fetch controller for the IF stage
// Purpose: issues one word fetch at a time (req/ack + rvalid), fills IF/ID, handles
//   stall (via a one-entry skid buffer), redirect/flush and stale responses.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   Stall, Redirect, RedirectPc   hazard stall; taken branch/jump and its target
//   ImemReq/ImemAddr/ImemAck      fetch request channel
//   ImemRvalid/ImemRdata          fetch response channel
//   IfValid/IfPc/IfPc4/IfInst     IF/ID register contents
//   FetchMisalign                 one-cycle pulse for a misaligned redirect target
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  output logic        IfValid,
  output logic [31:0] IfPc,
  output logic [31:0] IfPc4,
  output logic [31:0] IfInst,
  output logic        FetchMisalign
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        misalign_q;
  logic [31:0] skid_pc_q, skid_inst_q;
  logic        skid_we;

  logic        ifid_load;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic        if_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IF_BOOT;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      misalign_q  <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      misalign_q <= Redirect & (|RedirectPc[1:0]);
      if (skid_we) begin
        skid_pc_q   <= pc_q;
        skid_inst_q <= ImemRdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    skid_we   = 1'b0;
    ifid_load = 1'b0;
    ifid_pc   = pc_q;
    ifid_inst = ImemRdata;

    unique case (state_q)
      IF_BOOT: state_d = IF_REQ;
      IF_REQ: begin
        if (ImemAck) begin
          state_d = IF_WAIT;
          // The accepted address is the old Pc; its response must not reach IF/ID.
          kill_d  = Redirect;
        end
      end
      IF_WAIT: begin
        if (ImemRvalid) begin
          if (kill_q || Redirect) begin
            kill_d  = 1'b0;
            state_d = IF_REQ;
          end else if (!Stall || !if_valid) begin
            ifid_load = 1'b1;
            pc_d      = pc_q + 32'd4;
            state_d   = IF_REQ;
          end else begin
            // IF/ID is occupied and held; park the response rather than lose it.
            skid_we = 1'b1;
            state_d = IF_HOLD;
          end
        end else if (Redirect) begin
          kill_d = 1'b1;
        end
      end
      IF_HOLD: begin
        if (Redirect) begin
          state_d = IF_REQ;
        end else if (!Stall) begin
          ifid_load = 1'b1;
          ifid_pc   = skid_pc_q;
          ifid_inst = skid_inst_q;
          pc_d      = pc_q + 32'd4;
          state_d   = IF_REQ;
        end
      end
      default: state_d = IF_BOOT;
    endcase

    if (Redirect) pc_d = word_align(RedirectPc);
  end

  pc_fetch_if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(Redirect),
    .load_i (ifid_load),
    .stall_i(Stall),
    .pc_i   (ifid_pc),
    .inst_i (ifid_inst),
    .valid_o(if_valid),
    .pc_o   (IfPc),
    .inst_o (IfInst)
  );

  assign ImemReq       = (state_q == IF_REQ);
  assign ImemAddr      = pc_q;
  assign IfValid       = if_valid;
  assign IfPc4         = IfPc + 32'd4;
  assign FetchMisalign = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - scoreboard bench for pc_fetch with random stall/redirect/memory timing
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPc;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;
  logic        IfValid;
  logic [31:0] IfPc;
  logic [31:0] IfPc4;
  logic [31:0] IfInst;
  logic        FetchMisalign;

  pc_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Stall        (Stall),
    .Redirect     (Redirect),
    .RedirectPc   (RedirectPc),
    .ImemReq      (ImemReq),
    .ImemAddr     (ImemAddr),
    .ImemAck      (ImemAck),
    .ImemRvalid   (ImemRvalid),
    .ImemRdata    (ImemRdata),
    .IfValid      (IfValid),
    .IfPc         (IfPc),
    .IfPc4        (IfPc4),
    .IfInst       (IfInst),
    .FetchMisalign(FetchMisalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t       sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          delivered = 0;
  int          delivered_all = 0;
  bit          in_reset = 1'b1;
  logic [31:0] exp_fetch = RST_PC;

  // memory model state
  bit          pend = 1'b0;
  int          lat = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5679;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, applied at the falling edge.
  task automatic step(input bit rnd);
    logic [31:0] tgt;
    ImemRvalid = 1'b0;
    ImemRdata  = $urandom;
    if (pend) begin
      if (lat == 0) begin
        ImemRvalid = 1'b1;
        ImemRdata  = mem_word(pend_addr);
        pend       = 1'b0;
      end else begin
        lat--;
      end
    end else if (rnd && !ImemReq && $urandom_range(0, 15) == 0) begin
      ImemRvalid = 1'b1;                 // stray response, must be ignored
      ImemRdata  = 32'hDEAD_BEEF;
    end

    ImemAck = 1'b0;
    if (ImemReq && (!rnd || $urandom_range(0, 2) != 0)) ImemAck = 1'b1;

    Stall    = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
    Redirect = rnd ? ($urandom_range(0, 11) == 0) : 1'b0;
    tgt      = $urandom_range(0, 4095);
    if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
    RedirectPc = Redirect ? tgt : $urandom;

    if (ImemAck) begin
      check32("ack_addr", ImemAddr, exp_fetch);
      sb_q.push_back('{pc: exp_fetch, inst: mem_word(exp_fetch)});
      pend      = 1'b1;
      pend_addr = ImemAddr;
      lat       = rnd ? $urandom_range(0, 3) : 0;
    end
    if (Redirect) begin
      sb_q.delete();
      exp_fetch = tgt & 32'hFFFF_FFFC;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_req"}, {31'b0, ImemReq}, 32'd0);
    check32({tag, "_addr"}, ImemAddr, RST_PC);
    check32({tag, "_valid"}, {31'b0, IfValid}, 32'd0);
    check32({tag, "_pc"}, IfPc, 32'd0);
    check32({tag, "_inst"}, IfInst, NOP);
    check32({tag, "_misalign"}, {31'b0, FetchMisalign}, 32'd0);
  endtask

  // Back-to-back fetches with a one-cycle memory: 3 instructions after 7 edges.
  task automatic directed_start();
    @(negedge clk);
    sb_q.delete();
    pend      = 1'b0;
    exp_fetch = RST_PC;
    delivered = 0;
    rst_n     = 1'b1;
    in_reset  = 1'b0;
    repeat (6) begin
      @(negedge clk);
      step(1'b0);
    end
    @(negedge clk);
    check32("b2b_count", delivered, 32'd3);
    step(1'b0);
  endtask

  // Monitor: samples just after each rising edge and pops the scoreboard.
  initial begin : monitor
    bit          valid_prev;
    logic [31:0] last_pc;
    item_t       it;
    valid_prev = 1'b0;
    last_pc    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!in_reset && rst_n) begin
        check32("misalign", {31'b0, FetchMisalign},
                {31'b0, Redirect && (RedirectPc[1:0] != 2'b00)});
        if (Redirect) begin
          check32("flush_valid", {31'b0, IfValid}, 32'd0);
          check32("flush_inst", IfInst, NOP);
        end else if (valid_prev && Stall) begin
          check32("stall_keep", {31'b0, IfValid}, 32'd1);
        end
        if (IfValid) begin
          check32("pc4", IfPc4, IfPc + 32'd4);
          if (!valid_prev || !Stall) begin
            if (sb_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_inst actual_pc=%h required=none", IfPc);
            end else begin
              it = sb_q.pop_front();
              check32("if_pc", IfPc, it.pc);
              check32("if_inst", IfInst, it.inst);
              exp_fetch = it.pc + 32'd4;
              delivered++;
              delivered_all++;
            end
          end else begin
            check32("hold_pc", IfPc, last_pc);
          end
          last_pc = IfPc;
        end
      end
      valid_prev = IfValid;
    end
  end

  initial begin : driver
    bit found;
    rst_n      = 1'b0;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPc = '0;
    ImemAck    = 1'b0;
    ImemRvalid = 1'b0;
    ImemRdata  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");

    directed_start();
    repeat (1500) begin
      @(negedge clk);
      step(1'b1);
    end

    // Async reset while a fetch is outstanding.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      step(1'b1);
      if (pend) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_state actual=none required=outstanding_fetch");
    end
    @(posedge clk);
    #3;
    in_reset = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    Stall    = 1'b0;
    Redirect = 1'b0;
    ImemAck  = 1'b0;
    ImemRvalid = 1'b0;

    directed_start();
    repeat (1500) begin
      @(negedge clk);
      step(1'b1);
    end
    @(negedge clk);
    Stall = 1'b0;
    Redirect = 1'b0;
    repeat (3) @(negedge clk);

    total++;
    if (delivered_all < 100) begin
      bad++;
      $display("FAIL throughput actual=%0d required>=100", delivered_all);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
